tx_sched_arbiter: RTL and testbench
===================================

// Module: tx_sched_arbiter
// PURPOSE
//   Shares one transmit_engine (UART TX serializer) among NUM_REQ byte requesters.
//   Grants requesters round-robin, pulses load with the granted byte, and tracks the
//   engine's TxRDY busy/idle cycle.
//   Shadows the frame config (EIGHT/PEN/OHEL/BAUD) so settings never change mid-frame.
//   Sits between the requester-side logic and transmit_engine in the TX path.
// PARAMETERS
//   NUM_REQ       4   number of requesters, 2..8
//   BUSY_TIMEOUT  15  max clk cycles after load for TxRDY to fall before an error is flagged
// PORTS
//   clk        in   1          system clock, rising edge
//   rst        in   1          asynchronous, active-low reset
//   req        in   NUM_REQ    per-requester level request; held until ack
//   req_data   in   8*NUM_REQ  byte of requester i at [8*i+7:8*i]
//   ack        out  NUM_REQ    one-cycle pulse: byte of requester i handed to engine
//   cfg_in     in   7          {BAUD[3:0],EIGHT,PEN,OHEL} requested frame config
//   TxRDY      in   1          engine idle/ready (1 = ready)
//   load       out  1          one-cycle pulse to engine
//   out_port   out  8          byte to engine, stable from load until next grant
//   EIGHT,PEN,OHEL out 1 each  shadowed config to engine
//   BAUD       out  4          shadowed baud select to engine
//   grant_id   out  3          index of last granted requester
//   busy       out  1          1 whenever FSM != IDLE
//   err_to     out  1          one-cycle pulse on busy timeout
// BEHAVIOUR
//   Reset (rst=0, async): load=0, out_port=8'h00, ack=0, EIGHT=PEN=OHEL=0, BAUD=4'h0,
//     grant_id=0, busy=0, err_to=0, FSM=IDLE, rr pointer=NUM_REQ-1 (req[0] wins first).
//   Reset mid-frame aborts immediately; no ack is issued for the aborted grant.
//   FSM states: IDLE -> LOAD -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//   IDLE: cfg shadow <= cfg_in every cycle.
//     If TxRDY=1 and |req: pick the winner, capture req_data[winner] into out_port,
//     set grant_id, go to LOAD.
//     If TxRDY=0: no grant (engine busy, e.g. out of reset).
//   LOAD (1 cycle): load=1, ack[grant_id]=1. Go to WAIT_BUSY; clear the timeout counter.
//   WAIT_BUSY: TxRDY=0 -> WAIT_DONE.
//     Counter reaches BUSY_TIMEOUT with TxRDY still 1 -> err_to=1 for one cycle, go to IDLE.
//   WAIT_DONE: wait for TxRDY=1, then go to IDLE. No timeout here (frame length depends on BAUD).
//   Latency: req asserted in IDLE with TxRDY=1 -> load and ack 2 clks later
//     (1 registered grant + LOAD). Back-to-back frames: minimum one IDLE cycle between frames.
//   Round-robin: search starts at (pointer+1) mod NUM_REQ; pointer <= winner on grant.
//     Lone requester is re-granted every frame.
//   req sampled only in IDLE. Dropping req after grant has no effect; the byte is already captured.
//   cfg_in changes outside IDLE are ignored until the next IDLE cycle.
//   ack and load are asserted in the same cycle, never otherwise.
// CONFIGURATION
//   TX_PRIO_EN defined: req[0] has strict priority and wins whenever asserted in IDLE.
//     The other requesters stay round-robin among themselves.
//     A grant to req[0] does not move the rr pointer.
//   TX_PRIO_EN undefined: pure round-robin over all NUM_REQ.
// STRUCTURE
//   Package tx_sched_pkg holds:
//     - FSM state encoding (IDLE=2'd0, LOAD=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3)
//     - CFG_W=7 and the cfg field offsets
//     - reset constants
//   Sub-module rr_arbiter: combinational masked priority encoder
//     inputs: req, pointer, enable; outputs: winner index, valid.
//     Pointer register stays in tx_sched_arbiter.
// TESTING
//   1. Reset, TxRDY=1, req=4'b0001, data0=8'hA5
//      -> load pulse on clk 2, out_port=8'hA5, ack=4'b0001, busy=1.
//   2. req=4'b1111 held, engine model drops TxRDY 1 clk after load for 20 clks
//      -> grants 0,1,2,3,0 in order; exactly one ack per frame.
//   3. TxRDY held 1 after load (dead engine)
//      -> err_to pulse 15 clks after load, FSM back to IDLE, next grant proceeds.
//   4. cfg_in changed from 7'h58 to 7'h5F during WAIT_DONE
//      -> EIGHT/PEN/OHEL/BAUD unchanged until the IDLE cycle, then 7'h5F.
//   5. rst=0 asserted in WAIT_DONE
//      -> all outputs at reset values in the same cycle, no ack; after release req[0] wins first.
//   6. TX_PRIO_EN: req=4'b1111 repeatedly
//      -> req[0] granted every frame. Drop req[0] -> 1,2,3 rotate.

Source files
------------

// File: rtl/tx_sched_arbiter_pkg.sv
// Shared definitions for the TX scheduler arbiter: FSM encoding, frame-config
// field layout, reset constants and a small one-hot helper.
package tx_sched_pkg;

  // FSM encoding
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD      = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  // Frame config layout: {BAUD[3:0], EIGHT, PEN, OHEL}
  localparam int CFG_W        = 7;
  localparam int CFG_OHEL     = 0;
  localparam int CFG_PEN      = 1;
  localparam int CFG_EIGHT    = 2;
  localparam int CFG_BAUD_LSB = 3;

  // Reset values
  localparam logic [7:0]       RST_OUT_PORT = 8'h00;
  localparam logic [CFG_W-1:0] RST_CFG      = 7'h00;
  localparam logic [2:0]       RST_GRANT_ID = 3'd0;

  // One-hot decode of a requester index (up to 8 requesters)
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'd1 << idx;
  endfunction

endpackage

// File: rtl/tx_sched_arbiter_if.sv
// Requester/engine-side bundle of the TX scheduler arbiter. The master side
// (requesters plus engine status) drives requests, data, config and TxRDY;
// the slave side (the arbiter) drives grants, load, byte and shadowed config.
interface tx_sched_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic [6:0]           cfg_in;
  logic                 TxRDY;
  logic                 load;
  logic [7:0]           out_port;
  logic                 EIGHT;
  logic                 PEN;
  logic                 OHEL;
  logic [3:0]           BAUD;
  logic [2:0]           grant_id;
  logic                 busy;
  logic                 err_to;

  modport master (
    output req, req_data, cfg_in, TxRDY,
    input  ack, load, out_port, EIGHT, PEN, OHEL, BAUD, grant_id, busy, err_to
  );

  modport slave (
    input  req, req_data, cfg_in, TxRDY,
    output ack, load, out_port, EIGHT, PEN, OHEL, BAUD, grant_id, busy, err_to
  );
endinterface

// File: rtl/tx_sched_arbiter_rr_arbiter.sv
// Combinational round-robin picker: scans requests starting at the slot after
// ptr (wrapping) and reports the first asserted one. The pointer register
// itself lives in the parent so it can decide when the pointer moves.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  input  logic               enable,
  output logic [2:0]         winner,
  output logic               valid
);

  logic [7:0] req_pad_s;
  logic [3:0] idx_s;

  assign req_pad_s = 8'(req);

  // Masked priority scan from ptr+1 around to ptr; first hit wins
  always_comb begin
    winner = 3'd0;
    valid  = 1'b0;
    idx_s  = 4'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_s = 4'(ptr) + 4'(k);
      if (idx_s >= 4'(NUM_REQ)) begin
        idx_s = idx_s - 4'(NUM_REQ);
      end else begin
        idx_s = idx_s;
      end
      if (enable && !valid && req_pad_s[idx_s[2:0]]) begin
        winner = idx_s[2:0];
        valid  = 1'b1;
      end else begin
        winner = winner;
        valid  = valid;
      end
    end
  end

endmodule

// File: rtl/tx_sched_arbiter.sv
// TX scheduler arbiter: shares one UART transmit engine among NUM_REQ byte
// requesters, round-robin, with a shadowed frame config that only follows
// cfg_in while idle. Optional macro TX_PRIO_EN gives req[0] strict priority
// (the rest stay round-robin and a req[0] grant leaves the pointer alone).
module tx_sched_arbiter
  import tx_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  tx_sched_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  logic [1:0]         state_r, state_nxt_s;
  logic [2:0]         ptr_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               load_r, busy_r, err_r;
  logic [NUM_REQ-1:0] ack_r;
  logic [7:0]         out_port_r, data_sel_s;
  logic [2:0]         grant_id_r;
  logic [CFG_W-1:0]   cfg_r;
  logic [NUM_REQ-1:0] arb_req_s;
  logic [2:0]         arb_win_s, win_s;
  logic               arb_valid_s, grant_s, ptr_move_s, arb_en_s, timeout_s;
  logic [7:0]         ack_onehot_s;

  // Grants only happen while idle with the engine ready
  assign arb_en_s = (state_r == ST_IDLE) && bus.TxRDY;

`ifdef TX_PRIO_EN
  assign arb_req_s  = {bus.req[NUM_REQ-1:1], 1'b0};
  assign win_s      = bus.req[0] ? 3'd0 : arb_win_s;
  assign grant_s    = (bus.req[0] && arb_en_s) || arb_valid_s;
  assign ptr_move_s = !bus.req[0];
`else
  assign arb_req_s  = bus.req;
  assign win_s      = arb_win_s;
  assign grant_s    = arb_valid_s;
  assign ptr_move_s = 1'b1;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req    (arb_req_s),
    .ptr    (ptr_r),
    .enable (arb_en_s),
    .winner (arb_win_s),
    .valid  (arb_valid_s)
  );

  assign timeout_s = (state_r == ST_WAIT_BUSY) && bus.TxRDY &&
                     (cnt_r == CNT_W'(BUSY_TIMEOUT - 1));
  assign ack_onehot_s = onehot8(grant_id_r);

  // Select the winning requester's byte
  always_comb begin
    data_sel_s = RST_OUT_PORT;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_s == 3'(i)) begin
        data_sel_s = bus.req_data[8*i +: 8];
      end else begin
        data_sel_s = data_sel_s;
      end
    end
  end

  // Frame sequencing: IDLE -> LOAD -> WAIT_BUSY -> WAIT_DONE -> IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) state_nxt_s = ST_LOAD;
        else         state_nxt_s = ST_IDLE;
      end
      ST_LOAD: state_nxt_s = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (!bus.TxRDY)    state_nxt_s = ST_WAIT_DONE;
        else if (timeout_s) state_nxt_s = ST_IDLE;
        else               state_nxt_s = ST_WAIT_BUSY;
      end
      ST_WAIT_DONE: begin
        if (bus.TxRDY) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_WAIT_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, status pulses and the load/ack pair issued from the LOAD cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      load_r  <= 1'b0;
      ack_r   <= {NUM_REQ{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      load_r  <= (state_r == ST_LOAD);
      ack_r   <= (state_r == ST_LOAD) ? ack_onehot_s[NUM_REQ-1:0] : {NUM_REQ{1'b0}};
      err_r   <= timeout_s;
    end
  end

  // Capture byte, grant index and rr pointer on a grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_port_r <= RST_OUT_PORT;
      grant_id_r <= RST_GRANT_ID;
      ptr_r      <= 3'(NUM_REQ - 1);
    end else if (grant_s) begin
      out_port_r <= data_sel_s;
      grant_id_r <= win_s;
      if (ptr_move_s) ptr_r <= win_s;
    end
  end

  // Config shadow follows cfg_in only while idle, so a frame never sees a change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_r <= RST_CFG;
    end else if (state_r == ST_IDLE) begin
      cfg_r <= bus.cfg_in;
    end
  end

  // Timeout counter: cleared in LOAD, counts while waiting for TxRDY to fall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_LOAD) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_WAIT_BUSY) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign bus.load     = load_r;
  assign bus.ack      = ack_r;
  assign bus.out_port = out_port_r;
  assign bus.grant_id = grant_id_r;
  assign bus.busy     = busy_r;
  assign bus.err_to   = err_r;
  assign bus.OHEL     = cfg_r[CFG_OHEL];
  assign bus.PEN      = cfg_r[CFG_PEN];
  assign bus.EIGHT    = cfg_r[CFG_EIGHT];
  assign bus.BAUD     = cfg_r[CFG_BAUD_LSB +: 4];

endmodule

// File: tb/tb_tx_sched_arbiter.sv
// Self-checking bench for tx_sched_arbiter: a per-cycle vector table for the
// basic grant/load/ack flow, then hand sequences for rotation, timeout,
// config shadowing, mid-frame reset and (with TX_PRIO_EN) strict priority.
module tb_tx_sched_arbiter;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       txrdy;
    logic       load;
    logic [3:0] ack;
    logic [7:0] out;
    logic       busy;
    logic [2:0] gid;
    logic       err;
    logic [6:0] cfg;
  } vec_t;

  logic clk       = 1'b0;
  logic rst       = 1'b0;
  logic txrdy_tb  = 1'b1;
  logic eng_mode  = 1'b0;
  logic eng_txrdy = 1'b1;
  int   eng_cnt   = 0;
  int   n_vec     = 0;
  int   n_miss    = 0;
  int   ack_pulses = 0;
  vec_t tbl[17];

  tx_sched_arbiter_if #(.NUM_REQ(4)) bus();

  tx_sched_arbiter #(.NUM_REQ(4), .BUSY_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.TxRDY = eng_mode ? eng_txrdy : txrdy_tb;

  // Engine model: TxRDY falls the clock after load and stays low 20 clocks
  always @(posedge clk) begin
    if (!eng_mode) begin
      eng_txrdy <= 1'b1;
      eng_cnt   <= 0;
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) eng_txrdy <= 1'b1;
    end else if (bus.load) begin
      eng_txrdy <= 1'b0;
      eng_cnt   <= 20;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_load(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      tick();
      if (bus.ack != 4'b0000) ack_pulses++;
      if (bus.load) seen = 1'b1;
    end
  endtask

  function automatic logic [6:0] cfg_out();
    return {bus.BAUD, bus.EIGHT, bus.PEN, bus.OHEL};
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int n;
    int exp_g[5];

    bus.req      = 4'b0000;
    bus.req_data = {8'h33, 8'h22, 8'h11, 8'hA5};
    bus.cfg_in   = 7'h58;

    //                rst   req      rdy   load  ack      out    busy  gid   err   cfg
    tbl[0]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 8'h00, 1'b0, 3'd0, 1'b0, 7'h00};
    tbl[1]  = '{1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000, 8'hA5, 1'b1, 3'd0, 1'b0, 7'h58};
    tbl[2]  = '{1'b1, 4'b0001, 1'b1, 1'b1, 4'b0001, 8'hA5, 1'b1, 3'd0, 1'b0, 7'h58};
    tbl[3]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'hA5, 1'b1, 3'd0, 1'b0, 7'h58};
    tbl[4]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'hA5, 1'b1, 3'd0, 1'b0, 7'h58};
    tbl[5]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 8'hA5, 1'b0, 3'd0, 1'b0, 7'h58};
    tbl[6]  = '{1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000, 8'hA5, 1'b1, 3'd0, 1'b0, 7'h58};
    tbl[7]  = '{1'b1, 4'b0000, 1'b1, 1'b1, 4'b0001, 8'hA5, 1'b1, 3'd0, 1'b0, 7'h58};
    tbl[8]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'hA5, 1'b1, 3'd0, 1'b0, 7'h58};
    tbl[9]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 8'hA5, 1'b0, 3'd0, 1'b0, 7'h58};
    tbl[10] = '{1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000, 8'hA5, 1'b0, 3'd0, 1'b0, 7'h58};
    tbl[11] = '{1'b1, 4'b0100, 1'b1, 1'b0, 4'b0000, 8'h22, 1'b1, 3'd2, 1'b0, 7'h58};
    tbl[12] = '{1'b1, 4'b0000, 1'b1, 1'b1, 4'b0100, 8'h22, 1'b1, 3'd2, 1'b0, 7'h58};
    tbl[13] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h22, 1'b1, 3'd2, 1'b0, 7'h58};
    tbl[14] = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 8'h22, 1'b0, 3'd2, 1'b0, 7'h58};
    tbl[15] = '{1'b1, 4'b1010, 1'b1, 1'b0, 4'b0000, 8'h33, 1'b1, 3'd3, 1'b0, 7'h58};
    tbl[16] = '{1'b1, 4'b1010, 1'b1, 1'b1, 4'b1000, 8'h33, 1'b1, 3'd3, 1'b0, 7'h58};

    #1;
    for (int i = 0; i < 17; i++) begin
      rst      = tbl[i].rst;
      bus.req  = tbl[i].req;
      txrdy_tb = tbl[i].txrdy;
      tick();
      check($sformatf("v%0d.load", i), 32'(bus.load), 32'(tbl[i].load));
      check($sformatf("v%0d.ack", i), 32'(bus.ack), 32'(tbl[i].ack));
      check($sformatf("v%0d.out_port", i), 32'(bus.out_port), 32'(tbl[i].out));
      check($sformatf("v%0d.busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      check($sformatf("v%0d.grant_id", i), 32'(bus.grant_id), 32'(tbl[i].gid));
      check($sformatf("v%0d.err_to", i), 32'(bus.err_to), 32'(tbl[i].err));
      check($sformatf("v%0d.cfg", i), 32'(cfg_out()), 32'(tbl[i].cfg));
    end

`ifndef TX_PRIO_EN
    // Rotation with all four requesting and a live engine
    bus.req = 4'b0000;
    eng_mode = 1'b1;
    do_reset();
    exp_g = '{0, 1, 2, 3, 0};
    ack_pulses = 0;
    bus.req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_load(60, seen);
      check($sformatf("rr%0d.load_seen", f), 32'(seen), 32'd1);
      check($sformatf("rr%0d.grant_id", f), 32'(bus.grant_id), 32'(exp_g[f]));
      check($sformatf("rr%0d.ack", f), 32'(bus.ack), 32'(4'b0001 << exp_g[f]));
    end
    check("rr.ack_pulses", 32'(ack_pulses), 32'd5);
    bus.req = 4'b0000;
    eng_mode = 1'b0;
`endif

    // Dead engine: TxRDY never falls after load
    txrdy_tb = 1'b1;
    do_reset();
    bus.req = 4'b0001;
    wait_load(5, seen);
    check("to.load_seen", 32'(seen), 32'd1);
    n = 0;
    seen = 1'b0;
    while (n < 40 && !seen) begin
      tick();
      n++;
      if (bus.err_to) seen = 1'b1;
    end
    check("to.err_seen", 32'(seen), 32'd1);
    check("to.err_delay", 32'(n), 32'd15);
    check("to.busy_after", 32'(bus.busy), 32'd0);
    tick();
    check("to.err_one_cycle", 32'(bus.err_to), 32'd0);
    check("to.regrant_busy", 32'(bus.busy), 32'd1);
    tick();
    check("to.regrant_load", 32'(bus.load), 32'd1);
    check("to.regrant_ack", 32'(bus.ack), 32'(4'b0001));
    bus.req = 4'b0000;

    // Config change during WAIT_DONE waits for the next IDLE cycle
    txrdy_tb = 1'b1;
    bus.cfg_in = 7'h58;
    do_reset();
    bus.req = 4'b0001;
    tick();
    tick();
    bus.req = 4'b0000;
    txrdy_tb = 1'b0;
    tick();
    bus.cfg_in = 7'h5F;
    tick();
    tick();
    check("cfg.hold_wait_done", 32'(cfg_out()), 32'(7'h58));
    txrdy_tb = 1'b1;
    tick();
    check("cfg.idle_entry_busy", 32'(bus.busy), 32'd0);
    check("cfg.hold_idle_entry", 32'(cfg_out()), 32'(7'h58));
    tick();
    check("cfg.updated", 32'(cfg_out()), 32'(7'h5F));
    check("cfg.eight", 32'(bus.EIGHT), 32'd1);
    check("cfg.baud", 32'(bus.BAUD), 32'(4'hB));

    // Reset asserted in WAIT_DONE
    bus.cfg_in = 7'h58;
    txrdy_tb = 1'b1;
    do_reset();
    bus.req = 4'b0010;
    tick();
    tick();
    check("rst.pre_load", 32'(bus.load), 32'd1);
    bus.req = 4'b1111;
    txrdy_tb = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.load", 32'(bus.load), 32'd0);
    check("rst.ack", 32'(bus.ack), 32'd0);
    check("rst.out_port", 32'(bus.out_port), 32'h00);
    check("rst.grant_id", 32'(bus.grant_id), 32'd0);
    check("rst.cfg", 32'(cfg_out()), 32'(7'h00));
    tick();
    check("rst.ack_held", 32'(bus.ack), 32'd0);
    rst = 1'b1;
    txrdy_tb = 1'b1;
    tick();
    check("rst.first_gid", 32'(bus.grant_id), 32'd0);
    check("rst.first_out", 32'(bus.out_port), 32'hA5);
    tick();
    check("rst.first_ack", 32'(bus.ack), 32'(4'b0001));
    bus.req = 4'b0000;

`ifdef TX_PRIO_EN
    // Strict priority for req[0], rotation among the rest once it drops
    eng_mode = 1'b1;
    do_reset();
    bus.req = 4'b1111;
    for (int f = 0; f < 3; f++) begin
      wait_load(60, seen);
      check($sformatf("prio%0d.load_seen", f), 32'(seen), 32'd1);
      check($sformatf("prio%0d.grant_id", f), 32'(bus.grant_id), 32'd0);
    end
    bus.req = 4'b1110;
    for (int f = 0; f < 3; f++) begin
      wait_load(60, seen);
      check($sformatf("rot%0d.load_seen", f), 32'(seen), 32'd1);
      check($sformatf("rot%0d.grant_id", f), 32'(bus.grant_id), 32'(f + 1));
      check($sformatf("rot%0d.ack", f), 32'(bus.ack), 32'(4'b0001 << (f + 1)));
    end
    bus.req = 4'b0000;
    eng_mode = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
